change_dispenser: RTL and testbench

- Outbound counterpart of the coin-acceptor inputs (in_money_one/five/ten/twenty/fifty) that feed state_transitions.
- Takes the change amount computed by the vending FSM and emits single-cycle denomination pulses on out_money_* lines to the coin/note hopper.
- Uses greedy largest-first selection.
- Sits between state_transitions (change_money_buf, sys_Change) and the hopper drive pins.

---
 rtl/change_dispenser.sv | 167 ++++++++++++++++
 tb/tb_change_dispenser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy largest-first change dispenser: one hopper pulse per coin/note, then a recovery gap.
// Optional abort input enabled by defining DISPENSE_ABORT_EN.
module change_dispenser #(
    parameter int MONEY_W   = 8,
    parameter int PULSE_GAP = 4,
    parameter int CNT_W     = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic [MONEY_W-1:0] change_in,
`ifdef DISPENSE_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic [MONEY_W-1:0] remaining,
    output logic [CNT_W-1:0]   coin_cnt,
    output logic               out_money_one,
    output logic               out_money_five,
    output logic               out_money_ten,
    output logic               out_money_twenty,
    output logic               out_money_fifty
);

    localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t             state;
    logic [4:0]         out_pulse;
    logic [4:0]         pick;
    logic [MONEY_W-1:0] pulse_val;
    logic [GAP_W-1:0]   gap_cnt;
    logic               abort_sel;
    logic               abort_gap;

    // out_pulse bit order: {fifty, twenty, ten, five, one}
    assign out_money_fifty  = out_pulse[4];
    assign out_money_twenty = out_pulse[3];
    assign out_money_ten    = out_pulse[2];
    assign out_money_five   = out_pulse[1];
    assign out_money_one    = out_pulse[0];

    always_comb begin
        pick = 5'b00000;
        if (32'(remaining) >= 32'd50)
            pick = 5'b10000;
        else if (32'(remaining) >= 32'd20)
            pick = 5'b01000;
        else if (32'(remaining) >= 32'd10)
            pick = 5'b00100;
        else if (32'(remaining) >= 32'd5)
            pick = 5'b00010;
        else if (32'(remaining) >= 32'd1)
            pick = 5'b00001;
    end

    // The pulse register doubles as the selected denomination during PULSE.
    always_comb begin
        pulse_val = '0;
        case (out_pulse)
            5'b10000: pulse_val = MONEY_W'(50);
            5'b01000: pulse_val = MONEY_W'(20);
            5'b00100: pulse_val = MONEY_W'(10);
            5'b00010: pulse_val = MONEY_W'(5);
            5'b00001: pulse_val = MONEY_W'(1);
            default:  pulse_val = '0;
        endcase
    end

`ifdef DISPENSE_ABORT_EN
    logic abort_pend;

    // An abort seen during PULSE is held so it takes effect in the first GAP cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            abort_pend <= 1'b0;
        else if (state == PULSE)
            abort_pend <= abort;
        else if (state != GAP)
            abort_pend <= 1'b0;
    end

    assign abort_sel = abort;
    assign abort_gap = abort | abort_pend;
`else
    assign abort_sel = 1'b0;
    assign abort_gap = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            coin_cnt  <= '0;
            out_pulse <= '0;
            gap_cnt   <= '0;
        end else begin
            done      <= 1'b0;
            out_pulse <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= change_in;
                        coin_cnt  <= '0;
                        busy      <= 1'b1;
                        if (change_in == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    if (abort_sel) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        out_pulse <= pick;
                        state     <= PULSE;
                    end
                end
                PULSE: begin
                    remaining <= remaining - pulse_val;
                    if (coin_cnt != '1)
                        coin_cnt <= coin_cnt + 1'b1;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (abort_gap) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (gap_cnt == GAP_W'(PULSE_GAP - 1)) begin
                        if (remaining == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; per-cycle outputs are logged relative to the start edge.
module tb_change_dispenser;

    localparam int MAXO = 64;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic [7:0] change_in = 8'd0;
`ifdef DISPENSE_ABORT_EN
    logic       abort     = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic [3:0] coin_cnt;
    logic       out_money_one;
    logic       out_money_five;
    logic       out_money_ten;
    logic       out_money_twenty;
    logic       out_money_fifty;

    change_dispenser #(
        .MONEY_W  (8),
        .PULSE_GAP(4),
        .CNT_W    (4)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .start           (start),
        .change_in       (change_in),
`ifdef DISPENSE_ABORT_EN
        .abort           (abort),
`endif
        .busy            (busy),
        .done            (done),
        .remaining       (remaining),
        .coin_cnt        (coin_cnt),
        .out_money_one   (out_money_one),
        .out_money_five  (out_money_five),
        .out_money_ten   (out_money_ten),
        .out_money_twenty(out_money_twenty),
        .out_money_fifty (out_money_fifty)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse encoding: {fifty, twenty, ten, five, one}
    wire [4:0] pulses = {out_money_fifty, out_money_twenty, out_money_ten,
                         out_money_five, out_money_one};

    localparam logic [4:0] P50 = 5'b10000;
    localparam logic [4:0] P20 = 5'b01000;
    localparam logic [4:0] P10 = 5'b00100;
    localparam logic [4:0] P5  = 5'b00010;
    localparam logic [4:0] P1  = 5'b00001;

    int total = 0;
    int bad   = 0;
    int multi_hot = 0;

    logic [4:0] pulse_at [MAXO];
    logic       busy_at  [MAXO];
    logic       done_at  [MAXO];
    logic [7:0] rem_at   [MAXO];
    logic [3:0] cnt_at   [MAXO];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int num_pulses();
        int n = 0;
        for (int i = 0; i < MAXO; i++)
            if (pulse_at[i] != 5'b0) n++;
        return n;
    endfunction

    function automatic int num_done();
        int n = 0;
        for (int i = 0; i < MAXO; i++)
            if (done_at[i]) n++;
        return n;
    endfunction

    // Offset off means the cycle following start edge k+off-1, i.e. "cycle k+off".
    task automatic applyStimulus(input logic [7:0] amt, input int n_off,
                                 input int restart1, input int restart2,
                                 input int reset_off, input int abort_off);
        for (int i = 0; i < MAXO; i++) begin
            pulse_at[i] = '0;
            busy_at[i]  = 1'b0;
            done_at[i]  = 1'b0;
            rem_at[i]   = '0;
            cnt_at[i]   = '0;
        end
        @(negedge sys_clk);
        start     = 1'b1;
        change_in = amt;
        for (int off = 1; off < n_off; off++) begin
            @(negedge sys_clk);
            pulse_at[off] = pulses;
            busy_at[off]  = busy;
            done_at[off]  = done;
            rem_at[off]   = remaining;
            cnt_at[off]   = coin_cnt;
            if ($countones(pulses) > 1) multi_hot++;
            start = (off == restart1) || (off == restart2);
            if (off == restart1) change_in = 8'd99;
`ifdef DISPENSE_ABORT_EN
            abort = (off == abort_off);
`endif
            if (reset_off > 0 && off == reset_off) begin
                sys_rst_n = 1'b0;
                #1;
                checkOutput("async_reset_clears", int'({busy, done, remaining, coin_cnt, pulses}), 0);
            end
            if (reset_off > 0 && off == reset_off + 3)
                sys_rst_n = 1'b1;
        end
        start = 1'b0;
`ifdef DISPENSE_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        int seen;
        $display("[TB] change_dispenser bench starting");
        repeat (3) @(negedge sys_clk);
        checkOutput("reset_busy", int'(busy), 0);
        sys_rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (busy || done || remaining != 0 || coin_cnt != 0 || pulses != 0) seen++;
        end
        checkOutput("idle_activity", seen, 0);
        checkOutput("idle_remaining", int'(remaining), 0);
        checkOutput("idle_coin_cnt", int'(coin_cnt), 0);

        // 86 = 50 + 20 + 10 + 5 + 1, six cycles apart, done at k+31
        applyStimulus(8'd86, 36, 0, 0, 0, 0);
        checkOutput("c86_p1_fifty", int'(pulse_at[2]), int'(P50));
        checkOutput("c86_p2_twenty", int'(pulse_at[8]), int'(P20));
        checkOutput("c86_p3_ten", int'(pulse_at[14]), int'(P10));
        checkOutput("c86_p4_five", int'(pulse_at[20]), int'(P5));
        checkOutput("c86_p5_one", int'(pulse_at[26]), int'(P1));
        checkOutput("c86_npulses", num_pulses(), 5);
        checkOutput("c86_done_k31", int'(done_at[31]), 1);
        checkOutput("c86_ndone", num_done(), 1);
        checkOutput("c86_coin_cnt", int'(cnt_at[31]), 5);
        checkOutput("c86_remaining", int'(rem_at[31]), 0);
        checkOutput("c86_busy_in_done", int'(busy_at[31]), 1);
        checkOutput("c86_busy_after", int'(busy_at[32]), 0);

        // Zero change: straight to DONE in cycle k+1
        applyStimulus(8'd0, 6, 0, 0, 0, 0);
        checkOutput("c0_done_k1", int'(done_at[1]), 1);
        checkOutput("c0_busy_k1", int'(busy_at[1]), 1);
        checkOutput("c0_busy_k2", int'(busy_at[2]), 0);
        checkOutput("c0_npulses", num_pulses(), 0);
        checkOutput("c0_ndone", num_done(), 1);

        // Max 255 = 5 x 50 + 5, done at k+37
        applyStimulus(8'd255, 42, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("c255_fifty_%0d", i), int'(pulse_at[2 + 6 * i]), int'(P50));
        checkOutput("c255_five", int'(pulse_at[32]), int'(P5));
        checkOutput("c255_npulses", num_pulses(), 6);
        checkOutput("c255_done_k37", int'(done_at[37]), 1);
        checkOutput("c255_ndone", num_done(), 1);
        checkOutput("c255_coin_cnt", int'(cnt_at[37]), 6);
        checkOutput("c255_remaining", int'(rem_at[37]), 0);

        // 40 with start re-pulsed mid-job (change_in=99) and again in the DONE cycle
        applyStimulus(8'd40, 22, 3, 13, 0, 0);
        checkOutput("c40_p1_twenty", int'(pulse_at[2]), int'(P20));
        checkOutput("c40_p2_twenty", int'(pulse_at[8]), int'(P20));
        checkOutput("c40_npulses", num_pulses(), 2);
        checkOutput("c40_done_k13", int'(done_at[13]), 1);
        checkOutput("c40_ndone", num_done(), 1);
        checkOutput("c40_coin_cnt", int'(cnt_at[13]), 2);
        checkOutput("c40_busy_after_done", int'(busy_at[14]), 0);
        checkOutput("c40_busy_end", int'(busy_at[21]), 0);

        // 40 with reset asserted in the second GAP (cycle k+10)
        applyStimulus(8'd40, 24, 0, 0, 10, 0);
        checkOutput("rst40_npulses", num_pulses(), 2);
        checkOutput("rst40_ndone", num_done(), 0);
        checkOutput("rst40_busy_end", int'(busy_at[23]), 0);
        checkOutput("rst40_remaining_end", int'(rem_at[23]), 0);

`ifdef DISPENSE_ABORT_EN
        // 75 aborted in the first GAP: one fifty, 25 left undispensed
        applyStimulus(8'd75, 14, 0, 0, 0, 3);
        checkOutput("ab75_fifty", int'(pulse_at[2]), int'(P50));
        checkOutput("ab75_npulses", num_pulses(), 1);
        checkOutput("ab75_done_k4", int'(done_at[4]), 1);
        checkOutput("ab75_ndone", num_done(), 1);
        checkOutput("ab75_remaining", int'(rem_at[4]), 25);
        checkOutput("ab75_coin_cnt", int'(cnt_at[4]), 1);
`endif

        checkOutput("one_hot_pulses", multi_hot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
